// File: rtl/hazard_pkg.sv
// Shared enums for the pipeline hazard/sequencing controller: PC source select,
// trap cause reported to the CSR unit, and controller FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        SEQ      = 2'd0,
        REDIRECT = 2'd1,
        TRAP_VEC = 2'd2,
        EPC      = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        ECALL   = 2'd1,
        EBREAK  = 2'd2,
        BUS_ERR = 2'd3
    } trap_cause_t;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        MEM_WAIT     = 2'd1,
        TRAP_DRAIN_S = 2'd2,
        TRAP_FIRE    = 2'd3
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl.sv
// Stall/flush/PC-select producer for the 5-stage RV32 pipe: load-use bubbles,
// EX redirects, trap drain-then-fire sequencing and bounded data-memory waits.
//
// state        | meaning
// RUN          | normal issue; hazards resolved combinationally
// MEM_WAIT     | whole pipe frozen on dmem; wait counter bounds the stall
// TRAP_DRAIN_S | older instructions retire, nothing new enters EX
// TRAP_FIRE    | one-cycle trap entry / mret return pulse to CSR unit
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TRAP_DRAIN  = 2,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] rs1_addr_id,
    input  logic [4:0] rs2_addr_id,
    input  logic       rs1_used_id,
    input  logic       rs2_used_id,
    input  logic [4:0] rd_addr_ex,
    input  logic       rd_we_ex,
    input  logic       is_load_ex,
    input  logic       redirect_ex,
    input  logic       is_ecall_ex,
    input  logic       is_ebreak_ex,
    input  logic       is_mret_ex,
    input  logic       dmem_req_mem,
    input  logic       dmem_ready_mem,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       stall_mem,
    output logic       flush_id,
    output logic       flush_ex,
    output logic [1:0] pc_sel_o,
    output logic       trap_enter_o,
    output logic       trap_return_o,
    output logic [1:0] trap_cause_o
);

    localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int DW = $clog2(TRAP_DRAIN + 1);
    // with the timeout disabled the counter just parks at 1
    localparam logic [WW-1:0] W_LIMIT = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT : 1);
    localparam logic [DW-1:0] D_LIMIT = DW'(TRAP_DRAIN);
    localparam logic [DW-1:0] D_LAST  = DW'(TRAP_DRAIN - 1);

    function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs == rd);
    endfunction

    hz_state_t   r_state, w_state_nxt;
    logic [WW-1:0] r_wait, w_wait_nxt;
    logic [DW-1:0] r_drain, w_drain_nxt;
    trap_cause_t r_cause, w_cause_nxt;
    logic        r_mret, w_mret_nxt;

    logic w_load_use, w_mem_busy, w_trap_ex;
    logic w_run_eval, w_busy_ok;
    logic w_stall_if, w_stall_id, w_stall_ex, w_stall_mem, w_flush_id, w_flush_ex;
    logic w_enter, w_return;
    pc_sel_t     w_pc_sel;
    trap_cause_t w_cause_out;

    assign w_load_use = is_load_ex && rd_we_ex && (rd_addr_ex != 5'd0) &&
                        (src_hit(rs1_used_id, rs1_addr_id, rd_addr_ex) ||
                         src_hit(rs2_used_id, rs2_addr_id, rd_addr_ex));
    assign w_mem_busy = dmem_req_mem && !dmem_ready_mem;
    assign w_trap_ex  = is_ecall_ex || is_ebreak_ex || is_mret_ex;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_drain_nxt = r_drain;
        w_cause_nxt = r_cause;
        w_mret_nxt  = r_mret;
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_stall_ex  = 1'b0;
        w_stall_mem = 1'b0;
        w_flush_id  = 1'b0;
        w_flush_ex  = 1'b0;
        w_enter     = 1'b0;
        w_return    = 1'b0;
        w_pc_sel    = SEQ;
        w_cause_out = NONE;
        w_run_eval  = 1'b0;
        w_busy_ok   = 1'b0;

        unique case (r_state)
            RUN: begin
                w_run_eval = 1'b1;
                w_busy_ok  = 1'b1;
            end
            MEM_WAIT: begin
                if (!w_mem_busy) begin
                    w_run_eval  = 1'b1;
                    w_state_nxt = RUN;
                end else if ((MEM_TIMEOUT != 0) && (r_wait == W_LIMIT)) begin
                    w_cause_nxt = BUS_ERR;
                    w_mret_nxt  = 1'b0;
                    w_flush_id  = 1'b1;
                    w_flush_ex  = 1'b1;
                    w_drain_nxt = '0;
                    w_state_nxt = TRAP_DRAIN_S;
                end else begin
                    {w_stall_if, w_stall_id, w_stall_ex, w_stall_mem} = 4'b1111;
                    if (r_wait != W_LIMIT) w_wait_nxt = r_wait + WW'(1);
                end
            end
            TRAP_DRAIN_S: begin
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
                w_flush_ex = 1'b1;
                if (w_mem_busy) begin
                    w_stall_mem = 1'b1;
                end else if (r_drain == D_LAST) begin
                    w_state_nxt = TRAP_FIRE;
                end else if (r_drain != D_LIMIT) begin
                    w_drain_nxt = r_drain + DW'(1);
                end
            end
            TRAP_FIRE: begin
                w_flush_id  = 1'b1;
                w_flush_ex  = 1'b1;
                w_state_nxt = RUN;
                if (r_mret) begin
                    w_return = 1'b1;
                    w_pc_sel = EPC;
                end else begin
                    w_enter     = 1'b1;
                    w_pc_sel    = TRAP_VEC;
                    w_cause_out = r_cause;
                end
            end
            default: w_state_nxt = RUN;
        endcase

        if (w_run_eval) begin
            if (w_busy_ok && w_mem_busy) begin
                {w_stall_if, w_stall_id, w_stall_ex, w_stall_mem} = 4'b1111;
                w_wait_nxt  = WW'(1);
                w_state_nxt = MEM_WAIT;
            end else if (w_trap_ex) begin
                w_flush_id  = 1'b1;
                w_flush_ex  = 1'b1;
                w_cause_nxt = is_ecall_ex ? ECALL : (is_ebreak_ex ? EBREAK : NONE);
                w_mret_nxt  = !is_ecall_ex && !is_ebreak_ex;
                w_drain_nxt = '0;
                w_state_nxt = TRAP_DRAIN_S;
            end else if (redirect_ex) begin
                w_flush_id = 1'b1;
                w_flush_ex = 1'b1;
                w_pc_sel   = REDIRECT;
            end else if (w_load_use) begin
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
                w_flush_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RUN;
            r_wait  <= '0;
            r_drain <= '0;
            r_cause <= NONE;
            r_mret  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_drain <= w_drain_nxt;
            r_cause <= w_cause_nxt;
            r_mret  <= w_mret_nxt;
        end
    end

    // outputs are combinational from inputs, so gate them while reset is held
    assign stall_if      = rstn && w_stall_if;
    assign stall_id      = rstn && w_stall_id;
    assign stall_ex      = rstn && w_stall_ex;
    assign stall_mem     = rstn && w_stall_mem;
    assign flush_id      = rstn && w_flush_id;
    assign flush_ex      = rstn && w_flush_ex;
    assign trap_enter_o  = rstn && w_enter;
    assign trap_return_o = rstn && w_return;
    assign pc_sel_o      = rstn ? w_pc_sel : SEQ;
    assign trap_cause_o  = rstn ? w_cause_out : NONE;

endmodule
